// File: rtl/parking_pkg.sv
// Shared types and helpers for the multi-lane parking barrier controller.
package parking_pkg;

  typedef enum logic [1:0] {
    DOWN       = 2'b00,
    UP_START   = 2'b01,
    UP         = 2'b10,
    DOWN_START = 2'b11
  } tal_state_t;

  // Timer must hold the larger of the two reload values.
  function automatic int timer_width(input int move_c, input int hold_c);
    int m;
    m = (move_c > hold_c) ? move_c : hold_c;
    return $clog2(m + 1);
  endfunction

  // Lowest bit of lane k inside the packed tal_o vector.
  function automatic int tal_lo(input int lane);
    return 2 * lane;
  endfunction

endpackage

// File: rtl/gate_lane_fsm.sv
// One entry barrier: timed travel, car-passage detection, hold timeout and
// safety reversal. Raises refund for the cycle a granted slot goes unused.
module gate_lane_fsm
  import parking_pkg::*;
#(
  parameter int MOVE_CYCLES = 4,
  parameter int HOLD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       R,
  input  logic       grant,
  input  logic       car,
  output tal_state_t state,
  output logic       refund,
  output logic       is_down
);

  localparam int TW = timer_width(MOVE_CYCLES, HOLD_CYCLES);
  localparam logic [TW-1:0] MOVE_LOAD = TW'(MOVE_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] T_ONE     = TW'(1);
  localparam logic [TW-1:0] T_ZERO    = {TW{1'b0}};

  tal_state_t      state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            seen_q, seen_d;
  logic            refund_s;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    seen_d   = seen_q;
    refund_s = 1'b0;
    case (state_q)
      DOWN: begin
        if (grant) begin
          state_d = UP_START;
          timer_d = MOVE_LOAD;
        end else begin
          state_d = DOWN;
        end
      end
      UP_START: begin
        if (timer_q == T_ZERO) begin
          state_d = UP;
          timer_d = HOLD_LOAD;
          seen_d  = 1'b0;
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end
      // A car under the barrier freezes the hold timer until it has passed.
      UP: begin
        if (car) begin
          seen_d = 1'b1;
        end else if (seen_q) begin
          state_d = DOWN_START;
          timer_d = MOVE_LOAD;
        end else if (timer_q == T_ZERO) begin
          state_d  = DOWN_START;
          timer_d  = MOVE_LOAD;
          refund_s = 1'b1;
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end
      DOWN_START: begin
        if (car) begin
          state_d = UP_START;
          timer_d = MOVE_LOAD;
        end else if (timer_q == T_ZERO) begin
          state_d = DOWN;
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end
      default: begin
        state_d = DOWN;
        timer_d = T_ZERO;
        seen_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      state_q <= DOWN;
      timer_q <= T_ZERO;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      seen_q  <= seen_d;
    end
  end

  assign state   = state_q;
  assign refund  = refund_s;
  assign is_down = (state_q == DOWN);

endmodule

// File: rtl/parking_gate_ctrl.sv
// Multi-lane parking entry controller: priority admission against the shared
// occupancy count, per-lane barrier FSMs and the denied pulse.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int N_LANES     = 2,
  parameter int CAPACITY    = 8,
  parameter int MOVE_CYCLES = 4,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             R,
  input  logic [N_LANES-1:0]               valid_i,
  input  logic [N_LANES-1:0]               car_i,
  input  logic                             exit_i,
  output logic [2*N_LANES-1:0]             tal_o,
  output logic [$clog2(CAPACITY+1)-1:0]    count_o,
  output logic                             full_o,
  output logic [N_LANES-1:0]               denied_o
);

  localparam int CW = $clog2(CAPACITY + 1);
  // Headroom so count + grants cannot wrap before the subtraction.
  localparam int SW = CW + 4;
  localparam logic [SW-1:0] S_ONE  = SW'(1);
  localparam logic [SW-1:0] S_ZERO = {SW{1'b0}};

  logic [CW-1:0]       count_q, count_d;
  logic                full_q, full_d;
  logic [N_LANES-1:0]  denied_q, denied_d;
  logic [N_LANES-1:0]  grant_s, refund_s, is_down_s;
  tal_state_t          lane_state_s [N_LANES];
  logic [SW-1:0]       count_ext_s, free_s, n_grant_s, n_refund_s, sum_s;
  logic                exit_eff_s;

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    gate_lane_fsm #(
      .MOVE_CYCLES(MOVE_CYCLES),
      .HOLD_CYCLES(HOLD_CYCLES)
    ) u_lane (
      .clk    (clk),
      .R      (R),
      .grant  (grant_s[k]),
      .car    (car_i[k]),
      .state  (lane_state_s[k]),
      .refund (refund_s[k]),
      .is_down(is_down_s[k])
    );
    assign tal_o[tal_lo(k) +: 2] = lane_state_s[k];
  end

  always_comb begin
    grant_s     = {N_LANES{1'b0}};
    denied_d    = {N_LANES{1'b0}};
    n_grant_s   = S_ZERO;
    n_refund_s  = S_ZERO;
    count_ext_s = SW'(count_q);
    free_s      = SW'(CAPACITY) - count_ext_s;
    for (int k = 0; k < N_LANES; k++) begin
      if (valid_i[k] && is_down_s[k]) begin
        if (n_grant_s < free_s) begin
          grant_s[k] = 1'b1;
          n_grant_s  = n_grant_s + S_ONE;
        end else begin
          denied_d[k] = 1'b1;
        end
      end else begin
        denied_d[k] = 1'b0;
      end
      if (refund_s[k]) begin
        n_refund_s = n_refund_s + S_ONE;
      end else begin
        n_refund_s = n_refund_s;
      end
    end
    // An exit only counts if something is left after this cycle's refunds.
    exit_eff_s = exit_i && (count_ext_s > n_refund_s);
    sum_s      = count_ext_s + n_grant_s - n_refund_s - (exit_eff_s ? S_ONE : S_ZERO);
    count_d    = CW'(sum_s);
    full_d     = (count_d == CW'(CAPACITY));
  end

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      count_q  <= {CW{1'b0}};
      full_q   <= 1'b0;
      denied_q <= {N_LANES{1'b0}};
    end else begin
      count_q  <= count_d;
      full_q   <= full_d;
      denied_q <= denied_d;
    end
  end

  assign count_o  = count_q;
  assign full_o   = full_q;
  assign denied_o = denied_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl: default instance plus a CAPACITY=1
// instance for the admission-limit scenario.
module tb_parking_gate_ctrl;

  logic       clk = 1'b0;
  logic       R   = 1'b1;
  logic [1:0] valid_i = 2'b00, car_i = 2'b00;
  logic       exit_i = 1'b0;
  logic [3:0] tal_o;
  logic [3:0] count_o;
  logic       full_o;
  logic [1:0] denied_o;

  logic [1:0] valid_c1 = 2'b00, car_c1 = 2'b00;
  logic       exit_c1 = 1'b0;
  logic [3:0] tal_c1;
  logic [0:0] count_c1;
  logic       full_c1;
  logic [1:0] denied_c1;

  int n_checks = 0;
  int n_errors = 0;

  parking_gate_ctrl #(.N_LANES(2), .CAPACITY(8), .MOVE_CYCLES(4), .HOLD_CYCLES(16)) dut (
    .clk(clk), .R(R), .valid_i(valid_i), .car_i(car_i), .exit_i(exit_i),
    .tal_o(tal_o), .count_o(count_o), .full_o(full_o), .denied_o(denied_o)
  );

  parking_gate_ctrl #(.N_LANES(2), .CAPACITY(1), .MOVE_CYCLES(4), .HOLD_CYCLES(16)) dut_c1 (
    .clk(clk), .R(R), .valid_i(valid_c1), .car_i(car_c1), .exit_i(exit_c1),
    .tal_o(tal_c1), .count_o(count_c1), .full_o(full_c1), .denied_o(denied_c1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    R = 1'b1;
    valid_i = 2'b00; car_i = 2'b00; exit_i = 1'b0;
    valid_c1 = 2'b00; car_c1 = 2'b00; exit_c1 = 1'b0;
    @(negedge clk);
    R = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_checks++; if (tal_o !== 4'b0000) begin n_errors++; $display("FAIL reset_tal got %b exp 0000", tal_o); end
    n_checks++; if (count_o !== 4'd0) begin n_errors++; $display("FAIL reset_count got %0d exp 0", count_o); end
    n_checks++; if (full_o !== 1'b0) begin n_errors++; $display("FAIL reset_full got %b exp 0", full_o); end
    n_checks++; if (denied_o !== 2'b00) begin n_errors++; $display("FAIL reset_denied got %b exp 00", denied_o); end
    @(negedge clk);
    R = 1'b0;
    valid_i = 2'b01;
    tick();
    valid_i = 2'b00;
    repeat (4) tick();
    n_checks++; if (tal_o !== 4'b0010) begin n_errors++; $display("FAIL pre_reset_up got %b exp 0010", tal_o); end
    n_checks++; if (count_o !== 4'd1) begin n_errors++; $display("FAIL pre_reset_count got %0d exp 1", count_o); end
    #2 R = 1'b1;
    #1;
    n_checks++; if (tal_o !== 4'b0000) begin n_errors++; $display("FAIL async_reset_tal got %b exp 0000", tal_o); end
    n_checks++; if (count_o !== 4'd0) begin n_errors++; $display("FAIL async_reset_count got %0d exp 0", count_o); end
    @(negedge clk);
    R = 1'b0;
    valid_i = 2'b01;
    tick();
    valid_i = 2'b00;
    n_checks++; if (tal_o !== 4'b0001) begin n_errors++; $display("FAIL post_reset_grant got %b exp 0001", tal_o); end
  endtask

  task automatic test_normal_pass();
    apply_reset();
    valid_i = 2'b01;
    tick();
    valid_i = 2'b00;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (tal_o !== 4'b0001 || count_o !== 4'd1) begin n_errors++; $display("FAIL pass_up_start[%0d] got tal=%b cnt=%0d exp 0001/1", i, tal_o, count_o); end
      tick();
    end
    n_checks++; if (tal_o !== 4'b0010) begin n_errors++; $display("FAIL pass_up got %b exp 0010", tal_o); end
    car_i = 2'b01;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (tal_o !== 4'b0010) begin n_errors++; $display("FAIL pass_car_hold[%0d] got %b exp 0010", i, tal_o); end
    end
    car_i = 2'b00;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (tal_o !== 4'b0011 || count_o !== 4'd1) begin n_errors++; $display("FAIL pass_down_start[%0d] got tal=%b cnt=%0d exp 0011/1", i, tal_o, count_o); end
      tick();
    end
    n_checks++; if (tal_o !== 4'b0000 || count_o !== 4'd1) begin n_errors++; $display("FAIL pass_closed got tal=%b cnt=%0d exp 0000/1", tal_o, count_o); end
  endtask

  task automatic test_hold_timeout();
    apply_reset();
    valid_i = 2'b01;
    tick();
    valid_i = 2'b00;
    repeat (4) tick();
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (tal_o !== 4'b0010 || count_o !== 4'd1) begin n_errors++; $display("FAIL hold_up[%0d] got tal=%b cnt=%0d exp 0010/1", i, tal_o, count_o); end
      tick();
    end
    n_checks++; if (tal_o !== 4'b0011) begin n_errors++; $display("FAIL hold_timeout_state got %b exp 0011", tal_o); end
    n_checks++; if (count_o !== 4'd0) begin n_errors++; $display("FAIL hold_refund_count got %0d exp 0", count_o); end
    repeat (4) tick();
    n_checks++; if (tal_o !== 4'b0000 || count_o !== 4'd0) begin n_errors++; $display("FAIL hold_closed got tal=%b cnt=%0d exp 0000/0", tal_o, count_o); end
  endtask

  task automatic test_capacity();
    apply_reset();
    valid_c1 = 2'b11;
    tick();
    valid_c1 = 2'b00;
    n_checks++; if (tal_c1 !== 4'b0001) begin n_errors++; $display("FAIL cap_tal got %b exp 0001", tal_c1); end
    n_checks++; if (denied_c1 !== 2'b10) begin n_errors++; $display("FAIL cap_denied got %b exp 10", denied_c1); end
    n_checks++; if (full_c1 !== 1'b1 || count_c1 !== 1'b1) begin n_errors++; $display("FAIL cap_full got full=%b cnt=%0d exp 1/1", full_c1, count_c1); end
    tick();
    n_checks++; if (denied_c1 !== 2'b00) begin n_errors++; $display("FAIL cap_denied_pulse got %b exp 00", denied_c1); end
    valid_c1 = 2'b11;
    tick();
    valid_c1 = 2'b00;
    n_checks++; if (denied_c1 !== 2'b10) begin n_errors++; $display("FAIL cap_busy_lane_ignored got %b exp 10", denied_c1); end
  endtask

  task automatic test_safety_reversal();
    apply_reset();
    valid_i = 2'b01;
    tick();
    valid_i = 2'b00;
    repeat (4) tick();
    car_i = 2'b01;
    tick();
    car_i = 2'b00;
    tick();
    n_checks++; if (tal_o !== 4'b0011) begin n_errors++; $display("FAIL rev_ds1 got %b exp 0011", tal_o); end
    tick();
    n_checks++; if (tal_o !== 4'b0011) begin n_errors++; $display("FAIL rev_ds2 got %b exp 0011", tal_o); end
    car_i = 2'b01;
    tick();
    n_checks++; if (tal_o !== 4'b0001 || count_o !== 4'd1) begin n_errors++; $display("FAIL rev_reopen got tal=%b cnt=%0d exp 0001/1", tal_o, count_o); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (tal_o !== 4'b0001) begin n_errors++; $display("FAIL rev_up_start[%0d] got %b exp 0001", i, tal_o); end
    end
    tick();
    n_checks++; if (tal_o !== 4'b0010) begin n_errors++; $display("FAIL rev_up got %b exp 0010", tal_o); end
    tick();
    car_i = 2'b00;
    tick();
    n_checks++; if (tal_o !== 4'b0011) begin n_errors++; $display("FAIL rev_close got %b exp 0011", tal_o); end
    repeat (4) tick();
    n_checks++; if (tal_o !== 4'b0000 || count_o !== 4'd1) begin n_errors++; $display("FAIL rev_closed got tal=%b cnt=%0d exp 0000/1", tal_o, count_o); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    exit_i = 1'b1;
    tick();
    exit_i = 1'b0;
    n_checks++; if (count_o !== 4'd0) begin n_errors++; $display("FAIL exit_at_zero got %0d exp 0", count_o); end
    // Lane0 grants at edges 1, 12, 23; lane1 grant at edge 3 times out at edge 23.
    for (int e = 1; e <= 23; e++) begin
      valid_i = {(e == 3), (e == 1 || e == 12 || e == 23)};
      car_i   = {1'b0, (e == 6 || e == 17)};
      exit_i  = (e == 23);
      tick();
      if (e == 22) begin
        n_checks++; if (count_o !== 4'd3 || tal_o !== 4'b1000) begin n_errors++; $display("FAIL simul_pre got tal=%b cnt=%0d exp 1000/3", tal_o, count_o); end
      end
    end
    valid_i = 2'b00; car_i = 2'b00; exit_i = 1'b0;
    n_checks++; if (count_o !== 4'd2) begin n_errors++; $display("FAIL simul_count got %0d exp 2", count_o); end
    n_checks++; if (tal_o !== 4'b1101) begin n_errors++; $display("FAIL simul_tal got %b exp 1101", tal_o); end
    exit_i = 1'b1;
    tick();
    exit_i = 1'b0;
    n_checks++; if (count_o !== 4'd1 || full_o !== 1'b0) begin n_errors++; $display("FAIL exit_dec got cnt=%0d full=%b exp 1/0", count_o, full_o); end
  endtask

  initial begin
    test_reset();
    test_normal_pass();
    test_hold_timeout();
    test_capacity();
    test_safety_reversal();
    test_simultaneous();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
